// File: rtl/tff_counter_pkg.sv
// ============================================================================
// Module  : tff_counter_pkg
// Purpose : Shared constants and elaboration helpers for the T-flip-flop
//           up/down modulo counter and its testbench.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tff_counter_pkg;

    // Direction encoding of the counter's up input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Ceiling log2; used to check that MODULUS fits in WIDTH bits.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : tff_counter_pkg

`default_nettype wire

// File: rtl/tff_cell.sv
// ============================================================================
// Module  : tff_cell
// Purpose : Single T flip-flop with asynchronous active-low reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule : tff_cell

`default_nettype wire

// File: rtl/tff_updown_counter.sv
// ============================================================================
// Module  : tff_updown_counter
// Purpose : Up/down modulo counter built from a bank of T flip-flops, with
//           enable, clamped parallel load and combinational terminal count.
//           Define TFFCNT_SATURATE_EN to saturate instead of wrapping.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_updown_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Terminal value kept at WIDTH+1 bits so MODULUS = 2**WIDTH cannot overflow.
    localparam logic [WIDTH:0]   c_MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_MAX     = c_MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

`ifdef TFFCNT_SATURATE_EN
    localparam bit c_SATURATE = 1'b1;
`else
    localparam bit c_SATURATE = 1'b0;
`endif

    generate
        if (WIDTH < 1 || MODULUS < 2 || clog2_f(MODULUS) > WIDTH) begin : g_bad_params
            $error("tff_updown_counter: MODULUS must be in 2..2**WIDTH and WIDTH >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_load_val;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max   = ({1'b0, w_q} == c_MAX_EXT);
    assign w_at_zero  = (w_q == '0);
    assign w_load_val = ({1'b0, d} > c_MAX_EXT) ? c_MAX : d;

    always_comb begin
        w_next = w_q;
        if (load) begin
            w_next = w_load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (w_at_max) begin
                    w_next = c_SATURATE ? c_MAX : '0;
                end else begin
                    w_next = w_q + c_ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_next = c_SATURATE ? '0 : c_MAX;
                end else begin
                    w_next = w_q - c_ONE;
                end
            end
        end
    end

    // Each cell toggles exactly where the next count differs from the current one.
    assign w_t = w_next ^ w_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (w_t[i]),
                .q   (w_q[i])
            );
        end
    endgenerate

    assign q  = w_q;
    assign tc = en & ~load & (((up == DIR_UP) & w_at_max) | ((up == DIR_DN) & w_at_zero));

endmodule : tff_updown_counter

`default_nettype wire

// File: tb/tb_tff_updown_counter.sv
// ============================================================================
// Module  : tb_tff_updown_counter
// Purpose : Scoreboard bench for tff_updown_counter (WIDTH=4, MODULUS=10, or
//           MODULUS=16 when TFFCNT_SATURATE_EN is defined).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tff_updown_counter;
    import tff_counter_pkg::*;

    localparam int WIDTH = 4;
`ifdef TFFCNT_SATURATE_EN
    localparam int MODULUS = 16;
`else
    localparam int MODULUS = 10;
`endif

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             tc;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             up = DIR_UP;
    logic             load = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] q;
    logic             tc;

    logic             s_valid = 1'b0;
    exp_t             sb_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    tff_updown_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk  (clk),
        .rst  (rst_n),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q),
        .tc   (tc)
    );

    // Monitor: compares the presented q/tc against the oldest expectation.
    always @(negedge clk) begin
        if (s_valid) begin
            if (sb_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec = n_vec + 1;
                if (q !== e.q || tc !== e.tc) begin
                    n_err = n_err + 1;
                    $display("FAIL %s: got q=%0d tc=%b, expected q=%0d tc=%b",
                             e.name, q, tc, e.q, e.tc);
                end
            end
        end
    end

    // Apply one cycle of inputs just after the edge; expected q is the count
    // presented during this cycle, expected tc follows these inputs.
    task automatic vec(input logic r, input logic e, input logic u, input logic l,
                       input int dv, input int eq, input logic etc, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r;
        en    = e;
        up    = u;
        load  = l;
        d     = WIDTH'(dv);
        x.q   = WIDTH'(eq);
        x.tc  = etc;
        x.name = nm;
        sb_q.push_back(x);
        s_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        vec(0, 1'b0, DIR_UP, 1'b0, 0, 0, 1'b0, "reset_state");
        rst_n = 1'b1;

`ifdef TFFCNT_SATURATE_EN
        vec(1, 1'b0, DIR_UP, 1'b1, 14, 0, 1'b0, "sat_load14");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 14, 1'b0, "sat_up_14");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 15, 1'b1, "sat_up_15a");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 15, 1'b1, "sat_up_15b");
        vec(1, 1'b0, DIR_UP, 1'b1, 1, 15, 1'b0, "sat_up_15c_load1");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 1, 1'b0, "sat_dn_1");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 0, 1'b1, "sat_dn_0a");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 0, 1'b1, "sat_dn_0b");
        vec(1, 1'b0, DIR_DN, 1'b0, 0, 0, 1'b0, "sat_hold_0");
`else
        // Count up through the wrap.
        for (int i = 0; i < 10; i++) begin
            vec(1, 1'b1, DIR_UP, 1'b0, 0, i, (i == 9), "up_count");
        end
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 0, 1'b0, "up_wrap_0");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 1, 1'b0, "up_after_wrap_1");
        vec(1, 1'b0, DIR_UP, 1'b1, 0, 2, 1'b0, "up_after_wrap_2_load0");
        // Wrap down.
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 0, 1'b1, "dn_at_0");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 9, 1'b0, "dn_wrap_9");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 8, 1'b0, "dn_8");
        vec(1, 1'b0, DIR_DN, 1'b0, 0, 7, 1'b0, "dn_7_hold");
        // Load clamp and priority over en; tc gated by load at q==9.
        vec(1, 1'b1, DIR_UP, 1'b1, 13, 7, 1'b0, "load13_issue");
        vec(1, 1'b1, DIR_UP, 1'b1, 3, 9, 1'b0, "load_clamped_9");
        vec(1, 1'b0, DIR_UP, 1'b0, 0, 3, 1'b0, "load_3");
        // Mid-count reset.
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 3, 1'b0, "pre_rst_3");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 4, 1'b0, "pre_rst_4");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 5, 1'b0, "pre_rst_5");
        vec(1, 1'b0, DIR_UP, 1'b0, 0, 6, 1'b0, "pre_rst_6");
        vec(0, 1'b1, DIR_UP, 1'b0, 0, 0, 1'b0, "async_rst_0");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 0, 1'b0, "rst_edge_held_0");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 1, 1'b0, "resume_1");
        vec(1, 1'b0, DIR_UP, 1'b1, 5, 2, 1'b0, "resume_2_load5");
        // Direction flips each cycle.
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 5, 1'b0, "flip_5");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 6, 1'b0, "flip_6a");
        vec(1, 1'b1, DIR_UP, 1'b0, 0, 5, 1'b0, "flip_5b");
        vec(1, 1'b1, DIR_DN, 1'b0, 0, 6, 1'b0, "flip_6b");
        vec(1, 1'b0, DIR_UP, 1'b0, 0, 5, 1'b0, "hold_5a");
        vec(1, 1'b0, DIR_DN, 1'b1, 0, 5, 1'b0, "hold_5b_load0");
        // tc needs en even at the terminal value.
        vec(1, 1'b0, DIR_DN, 1'b0, 0, 0, 1'b0, "tc_gated_by_en");
        vec(1, 1'b0, DIR_UP, 1'b1, 9, 0, 1'b0, "load9");
        vec(1, 1'b0, DIR_UP, 1'b0, 0, 9, 1'b0, "tc_gated_by_en_9");
`endif
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tff_updown_counter

`default_nettype wire
